// File: rtl/ed_pixel_sequencer.sv
// ed_pixel_sequencer
//   Transmit-side front end for the error_diffusion engine. Accepts a
//   5-pixel neighbourhood window in parallel, streams it serially to the
//   engine, waits for the engine's done, captures the five results and
//   offers them upstream for write-back to the halftone frame buffer.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   win_valid/win_ready       upstream window handshake
//   win_pix0..win_pix4        center, right, lower-right, lower-center, lower-left
//   valid_o/data_o            serial pixel stream to the engine (registered)
//   done, result0..result4    engine completion and results
//   res_valid/res_ready       captured-result handshake
//   res0..res4                captured results, same ordering as win_pix
//   busy                      high whenever not IDLE
//   timeout_err               one-cycle pulse on watchdog abort
//
// Optional feature
//   ED_SEQ_TIMEOUT_EN : WAIT watchdog of TIMEOUT_CYC cycles (1..255).
//   When undefined WAIT lasts until done and timeout_err is tied to 0.

module ed_pixel_sequencer #(
    parameter int PIXEL_W     = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic [PIXEL_W-1:0] win_pix0,
    input  logic [PIXEL_W-1:0] win_pix1,
    input  logic [PIXEL_W-1:0] win_pix2,
    input  logic [PIXEL_W-1:0] win_pix3,
    input  logic [PIXEL_W-1:0] win_pix4,
    output logic               valid_o,
    output logic [PIXEL_W-1:0] data_o,
    input  logic               done,
    input  logic [PIXEL_W-1:0] result0,
    input  logic [PIXEL_W-1:0] result1,
    input  logic [PIXEL_W-1:0] result2,
    input  logic [PIXEL_W-1:0] result3,
    input  logic [PIXEL_W-1:0] result4,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PIXEL_W-1:0] res0,
    output logic [PIXEL_W-1:0] res1,
    output logic [PIXEL_W-1:0] res2,
    output logic [PIXEL_W-1:0] res3,
    output logic [PIXEL_W-1:0] res4,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg;
    logic [PIXEL_W-1:0] pix_in    [5];
    logic [PIXEL_W-1:0] result_in [5];
    logic [PIXEL_W-1:0] win_reg   [5];
    logic [PIXEL_W-1:0] res_reg   [5];
    logic               accept;
    logic               capture;
    logic               timeout_hit;

    assign pix_in[0]    = win_pix0;
    assign pix_in[1]    = win_pix1;
    assign pix_in[2]    = win_pix2;
    assign pix_in[3]    = win_pix3;
    assign pix_in[4]    = win_pix4;
    assign result_in[0] = result0;
    assign result_in[1] = result1;
    assign result_in[2] = result2;
    assign result_in[3] = result3;
    assign result_in[4] = result4;

    assign accept  = (state_reg == IDLE) && win_valid;
    assign capture = (state_reg == WAIT) && done;

`ifdef ED_SEQ_TIMEOUT_EN
    logic [7:0] wd_reg;

    // Held at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_reg <= 8'd0;
        else if (state_reg != WAIT)
            wd_reg <= 8'd0;
        else
            wd_reg <= wd_reg + 8'd1;
    end

    // done has priority: a coincident done captures instead of aborting.
    assign timeout_hit = (state_reg == WAIT) && !done && (wd_reg == WD_LAST);
`else
    // WD_LAST is referenced so the parameter stays used in this build.
    assign timeout_hit = 1'b0 && (WD_LAST == 8'd0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (win_valid)        state_next = SEND;
            SEND: if (cnt_reg == 3'd4)  state_next = WAIT;
            WAIT: if (done)             state_next = HOLD;
                  else if (timeout_hit) state_next = IDLE;
            HOLD: if (res_ready)        state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Serial stream, result handshake and error pulse. data_o for the first
    // pixel is loaded straight from the input on acceptance so the stream
    // starts the cycle after the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= 3'd0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        cnt_reg <= 3'd0;
                        valid_o <= 1'b1;
                        data_o  <= pix_in[0];
                    end
                end
                SEND: begin
                    if (cnt_reg == 3'd4) begin
                        cnt_reg <= 3'd0;
                        valid_o <= 1'b0;
                        data_o  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                        data_o  <= win_reg[cnt_reg + 3'd1];
                    end
                end
                WAIT: if (done)      res_valid <= 1'b1;
                HOLD: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_regs
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                win_reg[gi] <= '0;
            else if (accept)
                win_reg[gi] <= pix_in[gi];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                res_reg[gi] <= '0;
            else if (capture)
                res_reg[gi] <= result_in[gi];
        end
    end

    assign res0      = res_reg[0];
    assign res1      = res_reg[1];
    assign res2      = res_reg[2];
    assign res3      = res_reg[3];
    assign res4      = res_reg[4];
    assign win_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ed_pixel_sequencer.sv
// tb_ed_pixel_sequencer
//   Directed-vector bench for ed_pixel_sequencer. Outputs are sampled on
//   the falling edge; inputs are driven on the falling edge.

module tb_ed_pixel_sequencer;

    localparam int PW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          win_valid;
    logic          win_ready;
    logic [PW-1:0] win_pix0, win_pix1, win_pix2, win_pix3, win_pix4;
    logic          valid_o;
    logic [PW-1:0] data_o;
    logic          done;
    logic [PW-1:0] result0, result1, result2, result3, result4;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res0, res1, res2, res3, res4;
    logic          busy;
    logic          timeout_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int txn     = 0;

    ed_pixel_sequencer #(.PIXEL_W(PW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_pix0(win_pix0), .win_pix1(win_pix1), .win_pix2(win_pix2),
        .win_pix3(win_pix3), .win_pix4(win_pix4),
        .valid_o(valid_o), .data_o(data_o), .done(done),
        .result0(result0), .result1(result1), .result2(result2),
        .result3(result3), .result4(result4),
        .res_valid(res_valid), .res_ready(res_ready),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3), .res4(res4),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pk_at(input logic [39:0] pk, input int i);
        return pk[8*i +: 8];
    endfunction

    task automatic check_res(input string tag, input logic [39:0] pk);
        check({tag, "_res0"}, 32'(res0), 32'(pk_at(pk, 0)));
        check({tag, "_res1"}, 32'(res1), 32'(pk_at(pk, 1)));
        check({tag, "_res2"}, 32'(res2), 32'(pk_at(pk, 2)));
        check({tag, "_res3"}, 32'(res3), 32'(pk_at(pk, 3)));
        check({tag, "_res4"}, 32'(res4), 32'(pk_at(pk, 4)));
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge of the
    // first WAIT cycle. Optionally pulses done across one SEND edge.
    task automatic stream_window(input string tag, input logic [39:0] pk, input bit done_in_send);
        win_pix0  = pk_at(pk, 0);
        win_pix1  = pk_at(pk, 1);
        win_pix2  = pk_at(pk, 2);
        win_pix3  = pk_at(pk, 3);
        win_pix4  = pk_at(pk, 4);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        // Garbage on the window bus must not disturb the stored window.
        win_pix0 = 8'h5A; win_pix1 = 8'h5A; win_pix2 = 8'h5A;
        win_pix3 = 8'h5A; win_pix4 = 8'h5A;
        check({tag, "_win_ready_send"}, 32'(win_ready), 32'd0);
        check({tag, "_valid_p0"}, 32'(valid_o), 32'd1);
        check({tag, "_data_p0"}, 32'(data_o), 32'(pk_at(pk, 0)));
        if (done_in_send) done = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            done = 1'b0;
            check({tag, "_valid_p", 8'(8'h30 + i)}, 32'(valid_o), 32'd1);
            check({tag, "_data_p", 8'(8'h30 + i)}, 32'(data_o), 32'(pk_at(pk, i)));
        end
        @(negedge clk);
        check({tag, "_valid_wait"}, 32'(valid_o), 32'd0);
        check({tag, "_data_wait"}, 32'(data_o), 32'd0);
        check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    endtask

    // Called at the falling edge of WAIT cycle 1; done is driven during WAIT
    // cycle 'delay'. Returns at the falling edge of the first HOLD cycle.
    task automatic finish_engine(input string tag, input int delay, input logic [39:0] rp);
        for (int k = 1; k < delay; k++) begin
            check({tag, "_no_rv_wait"}, 32'(res_valid), 32'd0);
            @(negedge clk);
        end
        result0 = pk_at(rp, 0); result1 = pk_at(rp, 1); result2 = pk_at(rp, 2);
        result3 = pk_at(rp, 3); result4 = pk_at(rp, 4);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        result0 = 8'hEE; result1 = 8'hEE; result2 = 8'hEE;
        result3 = 8'hEE; result4 = 8'hEE;
        check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_win_ready_hold"}, 32'(win_ready), 32'd0);
        check_res(tag, rp);
    endtask

    task automatic release_results(input string tag);
        res_ready = 1'b1;
        check({tag, "_no_bypass"}, 32'(win_ready), 32'd0);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_rv_clear"}, 32'(res_valid), 32'd0);
        check({tag, "_win_ready_idle"}, 32'(win_ready), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        txn++;
        $display("txn %0d %s: window complete res=%02h %02h %02h %02h %02h",
                 txn, tag, res0, res1, res2, res3, res4);
    endtask

    localparam logic [39:0] W1 = {8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    localparam logic [39:0] R1 = {8'h03, 8'h05, 8'h01, 8'h07, 8'hFF};
    localparam logic [39:0] W2 = 40'h0;
    localparam logic [39:0] R2 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [39:0] W3 = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
    localparam logic [39:0] W4 = {8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    localparam logic [39:0] R4 = {8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1};

    initial begin
        rst = 1'b1; win_valid = 1'b0; done = 1'b0; res_ready = 1'b0;
        win_pix0 = '0; win_pix1 = '0; win_pix2 = '0; win_pix3 = '0; win_pix4 = '0;
        result0 = '0; result1 = '0; result2 = '0; result3 = '0; result4 = '0;
        repeat (2) @(negedge clk);
        check("rst_win_ready", 32'(win_ready), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_res("rst", 40'h0);
        rst = 1'b0;

        // done in IDLE is ignored
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("idle_done_rv", 32'(res_valid), 32'd0);
        check("idle_done_busy", 32'(busy), 32'd0);

        // Window 1, done 3 cycles into WAIT, held 10 cycles
        stream_window("w1", W1, 1'b0);
        finish_engine("w1", 3, R1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("w1_hold_rv", 32'(res_valid), 32'd1);
            check_res("w1_hold", R1);
        end
        release_results("w1");
        check_res("w1_kept", R1);

        // Window 2: all zeros, results overwrite
        stream_window("w2", W2, 1'b0);
        finish_engine("w2", 1, R2);
        release_results("w2");

        // Reset during SEND at cnt=2
        win_pix0 = pk_at(W3, 0); win_pix1 = pk_at(W3, 1); win_pix2 = pk_at(W3, 2);
        win_pix3 = pk_at(W3, 3); win_pix4 = pk_at(W3, 4);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("w3_data_p2", 32'(data_o), 32'(pk_at(W3, 2)));
        rst = 1'b1;
        #1;
        check("w3_rst_valid_o", 32'(valid_o), 32'd0);
        check("w3_rst_res_valid", 32'(res_valid), 32'd0);
        check("w3_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("w3_rst_win_ready", 32'(win_ready), 32'd1);
        check_res("w3_rst_clear", 40'h0);

        // Fresh window with done pulsed during SEND; only WAIT done counts
        stream_window("w4", W4, 1'b1);
        check("w4_send_done_rv", 32'(res_valid), 32'd0);
        finish_engine("w4", 4, R4);
        release_results("w4");

`ifdef ED_SEQ_TIMEOUT_EN
        // Withheld done: abort after TO WAIT cycles
        stream_window("to1", W1, 1'b0);
        repeat (TO - 1) begin
            check("to1_no_err", 32'(timeout_err), 32'd0);
            @(negedge clk);
        end
        check("to1_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("to1_err", 32'(timeout_err), 32'd1);
        check("to1_busy", 32'(busy), 32'd0);
        check("to1_rv", 32'(res_valid), 32'd0);
        check_res("to1_kept", R4);
        @(negedge clk);
        check("to1_err_pulse", 32'(timeout_err), 32'd0);
        txn++;
        $display("txn %0d to1: watchdog abort", txn);

        // done on the final watchdog cycle wins
        stream_window("to2", W2, 1'b0);
        finish_engine("to2", TO, R1);
        check("to2_no_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("to2_no_err2", 32'(timeout_err), 32'd0);
        check("to2_still_hold", 32'(res_valid), 32'd1);
        release_results("to2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
